// File: rtl/axi_word_writer.sv
`default_nettype none
// ============================================================================
//  Module   : axi_word_writer
//  Purpose  : Drains 128-bit packed words from the byte-packer word FIFO and
//             writes them to DDR as fixed-length AXI4 INCR write bursts. The
//             burst start address walks linearly through a circular region
//             [BASE_ADDR, BASE_ADDR + REGION_BYTES) and wraps to BASE_ADDR.
//             A burst is only started once a full burst worth of words is
//             waiting in the FIFO, so partial bursts are never issued.
//             Write-only master: no AR/R channels.
//
//  Ports    : clk               system clock, rising edge
//             rst_n             asynchronous active-low reset
//             word_fifo_dout    FIFO read data, valid the cycle after rd_en
//             word_fifo_empty   FIFO empty flag
//             word_fifo_count   FIFO occupancy in words
//             word_fifo_rd_en   one-cycle FIFO read pulse
//             m_aw*             AXI4 write-address channel
//             m_w*              AXI4 write-data channel
//             m_b*              AXI4 write-response channel
//             busy              engine is not idle
//             bresp_err         sticky error flag, any non-OKAY write response
//             words_written     running count of accepted W beats (mod 2^32)
//
//  Revision : 1.0  initial release
// ============================================================================
module axi_word_writer #(
    parameter int                    WORD_WIDTH   = 128,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    BURST_LEN    = 4,
    parameter int                    COUNT_W      = 5,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 32'h0001_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Word FIFO read side
    input  logic [WORD_WIDTH-1:0] word_fifo_dout,
    input  logic                  word_fifo_empty,
    input  logic [COUNT_W-1:0]    word_fifo_count,
    output logic                  word_fifo_rd_en,

    // AXI4 write-address channel
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic [7:0]            m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic                  m_awvalid,
    input  logic                  m_awready,

    // AXI4 write-data channel
    output logic [WORD_WIDTH-1:0] m_wdata,
    output logic [15:0]           m_wstrb,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,

    // AXI4 write-response channel
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,

    // Status
    output logic                  busy,
    output logic                  bresp_err,
    output logic [31:0]           words_written
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam int BEAT_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // Bytes covered by one burst; the burst start address steps by this.
    localparam logic [ADDR_WIDTH-1:0] c_BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BYTES_PER_WORD);
    // First address past the region. Computed in ADDR_WIDTH bits, so a
    // region ending exactly at the top of the address space compares
    // against zero, matching the ADDR_WIDTH-bit address adder below.
    localparam logic [ADDR_WIDTH-1:0] c_REGION_END  = BASE_ADDR + REGION_BYTES;
    localparam logic [COUNT_W-1:0]    c_BURST_WORDS = COUNT_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0]     c_LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_AW      = 3'd1,
        ST_FETCH   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WBEAT   = 3'd4,
        ST_BRESP   = 3'd5
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic                    awvalid_q;
    logic [WORD_WIDTH-1:0]   wdata_q;
    logic                    wvalid_q;
    logic                    wlast_q;
    logic                    bready_q;
    logic                    bresp_err_q;
    logic [31:0]             words_q;
    logic [BEAT_W-1:0]       beat_q;

    // ------------------------------------------------------------------------
    // Next burst start address: linear step with exact-equality wrap at the
    // end of the circular region.
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   awaddr_sum;
    logic [ADDR_WIDTH-1:0]   awaddr_d;

    assign awaddr_sum = awaddr_q + c_BURST_BYTES;
    assign awaddr_d   = (awaddr_sum == c_REGION_END) ? BASE_ADDR : awaddr_sum;

    // ------------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= BASE_ADDR;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            bresp_err_q <= 1'b0;
            words_q     <= '0;
            beat_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Wait for a complete burst of data; partial data stays
                    // in the FIFO until the packer supplies the rest.
                    if (word_fifo_count >= c_BURST_WORDS) begin
                        awvalid_q <= 1'b1;
                        state_q   <= ST_AW;
                    end
                end

                ST_AW: begin
                    // awvalid/awaddr held until the slave accepts.
                    if (m_awready) begin
                        awvalid_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // The read pulse is issued combinationally in this state;
                    // an empty FIFO simply holds us here.
                    if (!word_fifo_empty) begin
                        state_q <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    // FIFO data popped in FETCH is valid during this cycle.
                    wdata_q  <= word_fifo_dout;
                    wvalid_q <= 1'b1;
                    wlast_q  <= (beat_q == c_LAST_BEAT);
                    state_q  <= ST_WBEAT;
                end

                ST_WBEAT: begin
                    if (m_wready) begin
                        words_q  <= words_q + 32'd1;
                        wvalid_q <= 1'b0;
                        // wlast only ever accompanies a valid beat.
                        wlast_q  <= 1'b0;
                        if (wlast_q) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_BRESP;
                        end else begin
                            beat_q  <= beat_q + BEAT_W'(1);
                            state_q <= ST_FETCH;
                        end
                    end
                end

                ST_BRESP: begin
                    // bready is high for the whole state, so a bvalid that
                    // is already waiting is taken on the first cycle here.
                    if (m_bvalid) begin
                        bready_q <= 1'b0;
                        if (m_bresp != 2'b00) begin
                            bresp_err_q <= 1'b1;
                        end
                        // No retry: the region pointer advances regardless
                        // of the response code.
                        awaddr_q <= awaddr_d;
                        state_q  <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The FIFO returns data one cycle after the read strobe. Driving the
    // strobe directly from the FETCH state lets CAPTURE take the word in the
    // very next cycle, giving the three-cycle FETCH/CAPTURE/WBEAT beat loop.
    // FETCH lasts exactly one cycle whenever the FIFO is non-empty, so the
    // strobe is a single-cycle pulse per beat.
    assign word_fifo_rd_en = (state_q == ST_FETCH) && !word_fifo_empty;

    assign m_awaddr        = awaddr_q;
    assign m_awlen         = 8'(BURST_LEN - 1);
    assign m_awsize        = 3'b100;
    assign m_awburst       = 2'b01;
    assign m_awvalid       = awvalid_q;

    assign m_wdata         = wdata_q;
    assign m_wstrb         = {16{wvalid_q}};
    assign m_wlast         = wlast_q;
    assign m_wvalid        = wvalid_q;

    assign m_bready        = bready_q;

    assign busy            = (state_q != ST_IDLE);
    assign bresp_err       = bresp_err_q;
    assign words_written   = words_q;

endmodule
`default_nettype wire

// File: doc/axi_word_writer.md
Name: axi_word_writer

Overview:
- Downstream consumer of the 128-bit word FIFO that the byte packer fills.
- Drains packed words in fixed-length AXI4 INCR write bursts to DDR, using a linearly incrementing address within a circular region.
- Provides the DDR-side half of the UART-to-DDR data path.
- Write-only AXI4 master; the AR/R channels are not present.

Parameters:
- WORD_WIDTH, 128, FIFO word width and AXI data width (bits); must be 128.
- ADDR_WIDTH, 32, AXI address width.
- BURST_LEN, 4, beats per burst (1..16).
- COUNT_W, 5, width of the FIFO occupancy input.
- BASE_ADDR, 32'h0000_0000, first DDR byte address of the region; aligned to BURST_LEN*16.
- REGION_BYTES, 32'h0001_0000, region size in bytes; multiple of BURST_LEN*16.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- word_fifo_dout  in  WORD_WIDTH  FIFO read data; valid the cycle after word_fifo_rd_en.
- word_fifo_empty  in  1  FIFO empty flag.
- word_fifo_count  in  COUNT_W  FIFO occupancy in words.
- word_fifo_rd_en  out  1  one-cycle FIFO read pulse.
- m_awaddr  out  ADDR_WIDTH  burst start address.
- m_awlen  out  8  BURST_LEN-1, constant.
- m_awsize  out  3  3'b100 (16 bytes), constant.
- m_awburst  out  2  2'b01 (INCR), constant.
- m_awvalid  out  1  AW valid.
- m_awready  in  1  AW ready.
- m_wdata  out  WORD_WIDTH  write data.
- m_wstrb  out  16  all ones while m_wvalid is high, else 0.
- m_wlast  out  1  last beat of the burst.
- m_wvalid  out  1  W valid.
- m_wready  in  1  W ready.
- m_bresp  in  2  write response.
- m_bvalid  in  1  B valid.
- m_bready  out  1  B ready.
- busy  out  1  high whenever the state is not IDLE.
- bresp_err  out  1  sticky; set on any m_bresp != 2'b00.
- words_written  out  32  count of beats accepted, i.e. W handshakes.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE; all valids, word_fifo_rd_en, m_bready, m_wlast, busy and bresp_err = 0.
  - m_wdata = 0, words_written = 0, beat counter = 0, m_awaddr = BASE_ADDR.
  - Reset asserted mid-burst abandons the burst immediately; no completion is attempted.
- States: IDLE, AW, FETCH, CAPTURE, WBEAT, BRESP.
- IDLE:
  - Go to AW when word_fifo_count >= BURST_LEN.
  - If the count stays below BURST_LEN (partial data), remain in IDLE; no partial bursts are ever issued.
- AW:
  - m_awvalid is high and m_awaddr is held stable until m_awready.
  - On the handshake: m_awvalid <= 0, beat counter <= 0, go to FETCH.
  - m_awvalid never drops before the handshake.
- FETCH:
  - Assert word_fifo_rd_en for exactly one cycle, go to CAPTURE.
  - Assert it only if word_fifo_empty is 0; otherwise stall in FETCH. This is a defensive case and cannot occur when the count is honoured.
- CAPTURE:
  - m_wdata <= word_fifo_dout, m_wvalid <= 1, m_wlast <= (beat counter == BURST_LEN-1), go to WBEAT.
- WBEAT:
  - m_wdata, m_wlast and m_wvalid are held until m_wready.
  - On the handshake: words_written increments and m_wvalid <= 0.
  - If m_wlast: m_bready <= 1, go to BRESP. Otherwise beat counter increments, go to FETCH.
  - Throughput is one beat per 3 cycles minimum; this is acceptable at UART rates.
- BRESP:
  - m_bready stays high until m_bvalid.
  - On the handshake: m_bready <= 0; bresp_err |= (m_bresp != 0); go to IDLE.
  - Address update: m_awaddr <= m_awaddr + BURST_LEN*16. If the result equals BASE_ADDR + REGION_BYTES, m_awaddr <= BASE_ADDR instead (wrap).
  - The address advances even on an error response; there is no retry.
- Ordering and simultaneity:
  - W is never presented before the AW handshake completes.
  - An m_wready held high in advance is accepted on the first cycle m_wvalid is high.
  - m_bvalid arriving in the same cycle m_bready rises is accepted that cycle.
- Width rules:
  - words_written wraps modulo 2^32.
  - The address adder uses ADDR_WIDTH bits; the wrap compare is exact equality.
- Data ordering: FIFO word N of a burst goes on beat N, with no reordering. Byte 0 of the word (bits [7:0]) lands at the lowest address.

Test Plan:
- FIFO preloaded with 4 words 0x00..0F, 0x10..1F, 0x20..2F, 0x30..3F (byte-incrementing), AXI slave always ready -> one AW at 0x0, awlen = 3, 4 beats in order, wlast on beat 4 only; then words_written = 4 and m_awaddr = 0x40.
- word_fifo_count = 3 held for 100 cycles -> no m_awvalid, no word_fifo_rd_en, busy = 0; 4th word arrives -> burst starts within 2 cycles.
- Slave backpressure: m_awready delayed 5 cycles, m_wready toggling randomly, m_bvalid delayed 10 cycles -> m_awvalid, m_wvalid, m_wdata and m_wlast are held stable while stalled; exactly 4 rd_en pulses per burst; data matches the FIFO.
- REGION_BYTES = 0x80, three bursts -> addresses 0x00, 0x40, 0x00 (wrap).
- m_bresp = 2'b10 on burst 1, OKAY on burst 2 -> bresp_err = 1 and stays 1; burst 2 still issued at 0x40.
- rst_n pulsed low during beat 2 of a burst -> all outputs return to reset values asynchronously; after release, with 4 words in the FIFO, the next burst starts at BASE_ADDR.
